mem_port_arb: RTL

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/pdp8_pkg.sv | 25 ++
 rtl/mem_port_arb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pdp8_pkg.sv
// Shared widths and enums for the PDP-8 memory-port arbiter and its neighbours.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_e;

  typedef enum logic [1:0] {
    CL_NONE,
    CL_IFU,
    CL_EXRD,
    CL_EXWR
  } client_e;

endpackage

// File: rtl/mem_port_arb.sv
// Arbitrates fetch, execute-read and execute-write clients onto one single-port
// memory: one transaction in flight, exec_wr > exec_rd > ifu with anti-starvation.
module mem_port_arb
  import pdp8_pkg::*;
#(
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic                   ifu_rd_ack,
  input  logic                   exec_rd_req,
  input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [`DATA_WIDTH-1:0] exec_rd_data,
  output logic                   exec_rd_ack,
  input  logic                   exec_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [`DATA_WIDTH-1:0] exec_wr_data,
  output logic                   exec_wr_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`DATA_WIDTH-1:0] mem_wdata,
  input  logic [`DATA_WIDTH-1:0] mem_rdata,
  output logic                   busy
);

  localparam logic [2:0] LAT_LAST   = 3'(RD_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e             state_q;
  client_e                client_q;
  client_e                win_d;
  logic [3:0]             starve_q;
  logic [2:0]             lat_cnt_q;
  logic                   ifu_ack_q, exrd_ack_q, exwr_ack_q;
  logic                   mem_req_q, mem_we_q, busy_q;
  logic [`ADDR_WIDTH-1:0] mem_addr_q;
  logic [`DATA_WIDTH-1:0] mem_wdata_q, ifu_data_q, exrd_data_q;
  logic                   acking, ifu_ok, exrd_ok, exwr_ok;

  // The client being acked this cycle still holds its request; keep it out of the race.
  always_comb begin
    acking  = (state_q == ACK);
    ifu_ok  = ifu_rd_req  && !(acking && client_q == CL_IFU);
    exrd_ok = exec_rd_req && !(acking && client_q == CL_EXRD);
    exwr_ok = exec_wr_req && !(acking && client_q == CL_EXWR);
    win_d   = CL_NONE;
    if (state_q == IDLE || acking) begin
      if (ifu_ok && starve_q == STARVE_MAX) win_d = CL_IFU;
      else if (exwr_ok)                     win_d = CL_EXWR;
      else if (exrd_ok)                     win_d = CL_EXRD;
      else if (ifu_ok)                      win_d = CL_IFU;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      client_q    <= CL_NONE;
      starve_q    <= '0;
      lat_cnt_q   <= '0;
      ifu_ack_q   <= 1'b0;
      exrd_ack_q  <= 1'b0;
      exwr_ack_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      ifu_data_q  <= '0;
      exrd_data_q <= '0;
    end else begin
      ifu_ack_q   <= 1'b0;
      exrd_ack_q  <= 1'b0;
      exwr_ack_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE, ACK: begin
          if (win_d != CL_NONE) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            client_q  <= win_d;
            mem_req_q <= 1'b1;
            case (win_d)
              CL_IFU:  mem_addr_q <= ifu_rd_addr;
              CL_EXRD: mem_addr_q <= exec_rd_addr;
              CL_EXWR: begin
                mem_addr_q  <= exec_wr_addr;
                mem_wdata_q <= exec_wr_data;
                mem_we_q    <= 1'b1;
              end
              default: ;
            endcase
            // Only a grant that ifu actually competed for counts as a loss.
            if (win_d == CL_IFU)                     starve_q <= '0;
            else if (ifu_ok && starve_q < STARVE_MAX) starve_q <= starve_q + 4'd1;
          end else begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            client_q <= CL_NONE;
          end
        end
        ISSUE: begin
          if (client_q == CL_EXWR) begin
            state_q    <= ACK;
            exwr_ack_q <= 1'b1;
          end else begin
            state_q   <= WAIT;
            lat_cnt_q <= LAT_LAST;
          end
        end
        WAIT: begin
          if (lat_cnt_q == 3'd0) begin
            state_q <= ACK;
            if (client_q == CL_IFU) begin
              ifu_ack_q  <= 1'b1;
              ifu_data_q <= mem_rdata;
            end else begin
              exrd_ack_q  <= 1'b1;
              exrd_data_q <= mem_rdata;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ifu_rd_data  = ifu_data_q;
  assign ifu_rd_ack   = ifu_ack_q;
  assign exec_rd_data = exrd_data_q;
  assign exec_rd_ack  = exrd_ack_q;
  assign exec_wr_ack  = exwr_ack_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;

endmodule
